// File: rtl/fp_alu_cmd_master.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fp_alu_cmd_master : valid/ready command initiator for the FP ALU  (rev 1.0)
// Optional sticky-flag accumulator enabled by FP_ALU_STICKY_FLAGS_EN.
// ---------------------------------------------------------------------------
module fp_alu_cmd_master #(
  parameter int ALU_LATENCY = 2,
  parameter int TAG_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [31:0]      alu_operand_a,
  output logic [31:0]      alu_operand_b,
  output logic [2:0]       alu_operation,
  input  logic [31:0]      alu_result,
  input  logic             alu_exception,
  input  logic             alu_overflow,
  input  logic             alu_underflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic [2:0]       rsp_flags,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy,
  input  logic             sticky_clr,
  output logic [2:0]       sticky_flags
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [3:0] C_CNT_LOAD = 4'(ALU_LATENCY - 1);

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_result_q, rsp_result_d;
  logic [2:0]        rsp_flags_q, rsp_flags_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      op_q         <= 3'd0;
      a_q          <= 32'd0;
      b_q          <= 32'd0;
      tag_q        <= '0;
      cnt_q        <= 4'd0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= 32'd0;
      rsp_flags_q  <= 3'd0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      tag_q        <= tag_d;
      cnt_q        <= cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    tag_d        = tag_q;
    cnt_d        = cnt_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          tag_d = cmd_tag;
          if (cmd_op != 3'd0) begin
            // Operands only move for legal ops, so the ALU never sees illegal traffic.
            op_d    = cmd_op;
            a_d     = cmd_a;
            b_d     = cmd_b;
            cnt_d   = C_CNT_LOAD;
            state_d = ISSUE;
          end else begin
            rsp_result_d = 32'd0;
            rsp_flags_d  = 3'b100;
            rsp_valid_d  = 1'b1;
            state_d      = RESP;
          end
        end
      end
      ISSUE: begin
        if (cnt_q == 4'd0) begin
          rsp_result_d = alu_result;
          rsp_flags_d  = {alu_exception, alu_overflow, alu_underflow};
          rsp_valid_d  = 1'b1;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready     = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign alu_operation = (state_q == ISSUE) ? op_q : 3'd0;
  assign alu_operand_a = a_q;
  assign alu_operand_b = b_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_result    = rsp_result_q;
  assign rsp_flags     = rsp_flags_q;
  assign rsp_tag       = tag_q;

`ifdef FP_ALU_STICKY_FLAGS_EN
  logic       capture_w;
  logic [2:0] sticky_q, sticky_d;

  assign capture_w = ((state_q == ISSUE) && (cnt_q == 4'd0)) ||
                     ((state_q == IDLE) && cmd_valid && (cmd_op == 3'd0));

  // A clear coinciding with a capture keeps only the fresh flags.
  always_comb begin
    sticky_d = sticky_q;
    if (capture_w)
      sticky_d = sticky_clr ? rsp_flags_d : (sticky_q | rsp_flags_d);
    else if (sticky_clr)
      sticky_d = 3'b000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky_q <= 3'b000;
    else        sticky_q <= sticky_d;
  end

  assign sticky_flags = sticky_q;
`else
  logic unused_sticky_clr;
  assign unused_sticky_clr = sticky_clr;
  assign sticky_flags      = 3'b000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp_alu_cmd_master.sv
`default_nettype none
// tb_fp_alu_cmd_master : directed stimulus with a queue-based scoreboard and
// a behavioural ALU that returns garbage until its inputs have been held long enough.
module tb_fp_alu_cmd_master;
  localparam int L     = 2;
  localparam int TAG_W = 4;
`ifdef FP_ALU_STICKY_FLAGS_EN
  localparam bit STICKY_ON = 1'b1;
`else
  localparam bit STICKY_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [2:0] cmd_op = 3'd0;
  logic [31:0] cmd_a = 32'd0, cmd_b = 32'd0;
  logic [TAG_W-1:0] cmd_tag = '0;
  logic [31:0] alu_operand_a, alu_operand_b, alu_result;
  logic [2:0] alu_operation;
  logic alu_exception, alu_overflow, alu_underflow;
  logic rsp_valid, rsp_ready = 1'b1;
  logic [31:0] rsp_result;
  logic [2:0] rsp_flags;
  logic [TAG_W-1:0] rsp_tag;
  logic busy;
  logic sticky_clr = 1'b0;
  logic [2:0] sticky_flags;

  fp_alu_cmd_master #(.ALU_LATENCY(L), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
    .alu_operation(alu_operation), .alu_result(alu_result),
    .alu_exception(alu_exception), .alu_overflow(alu_overflow),
    .alu_underflow(alu_underflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_tag(rsp_tag), .busy(busy),
    .sticky_clr(sticky_clr), .sticky_flags(sticky_flags)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural ALU
  function automatic logic [34:0] alu_fn(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [31:0] r;
    logic [2:0]  f;
    r = 32'hBAD0_BAD0;
    f = 3'b111;
    case (op)
      3'd1: if (a == 32'h3F80_0000 && b == 32'h4000_0000) begin r = 32'h4040_0000; f = 3'b000; end
      3'd2: if (a == b) begin r = 32'h0; f = 3'b000; end
      3'd3: begin
        if (a == 32'h4000_0000 && b == 32'h4040_0000) begin r = 32'h40C0_0000; f = 3'b000; end
        else if (a == 32'h7F00_0000 && b == 32'h4000_0000) begin r = 32'h7F80_0000; f = 3'b110; end
        else if (a == 32'h0080_0000 && b == 32'h3F00_0000) begin r = 32'h0040_0000; f = 3'b001; end
      end
      3'd4: if (a == 32'h3F80_0000 && b == 32'h4000_0000) begin r = 32'h3F00_0000; f = 3'b000; end
      3'd5: begin r = a | b; f = {(r[30:23] == 8'hFF), 2'b00}; end
      3'd6: begin r = a & b; f = {(r[30:23] == 8'hFF), 2'b00}; end
      3'd7: begin r = ~a;    f = {(r[30:23] == 8'hFF), 2'b00}; end
      default: ;
    endcase
    return {f, r};
  endfunction

  logic [66:0] prev_key = '0;
  int hold = 0;
  always @(posedge clk) begin
    if (alu_operation != 3'd0) begin
      if ({alu_operation, alu_operand_a, alu_operand_b} == prev_key) hold <= hold + 1;
      else hold <= 1;
      prev_key <= {alu_operation, alu_operand_a, alu_operand_b};
    end else begin
      hold <= 0;
      prev_key <= '0;
    end
  end

  always @* begin
    logic [34:0] v;
    v = alu_fn(alu_operation, alu_operand_a, alu_operand_b);
    if (hold < L - 1) v = {3'b111, 32'hDEAD_BEEF};
    {alu_exception, alu_overflow, alu_underflow, alu_result} = v;
  end

  // Scoreboard
  typedef struct {
    logic [31:0]      res;
    logic [2:0]       fl;
    logic [TAG_W-1:0] tag;
    int               lat;
    int               acc;
  } exp_t;
  exp_t exp_q[$];

  bit prev_v = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (rsp_valid && !prev_v) begin
        if (exp_q.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
        else chk("rsp_latency", 32'(cyc - exp_q[0].acc + 1), 32'(exp_q[0].lat));
      end
      if (rsp_valid && exp_q.size() != 0) begin
        chk("rsp_result", rsp_result, exp_q[0].res);
        chk("rsp_flags", 32'(rsp_flags), 32'(exp_q[0].fl));
        chk("rsp_tag", 32'(rsp_tag), 32'(exp_q[0].tag));
        if (rsp_ready) void'(exp_q.pop_front());
      end
      prev_v = rsp_valid;
    end
  end

  task automatic push_exp(input logic [2:0] op, input logic [TAG_W-1:0] tag,
                          input logic [31:0] er, input logic [2:0] ef);
    exp_t e;
    e.res = er; e.fl = ef; e.tag = tag;
    e.lat = (op == 3'd0) ? 1 : L + 1;
    e.acc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] tag, input logic [31:0] er, input logic [2:0] ef);
    bit acc;
    int n;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag;
    acc = 1'b0;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      if (cmd_ready) acc = 1'b1;
    end
    if (!acc) begin
      chk("accept_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    push_exp(op, tag, er, ef);
    @(negedge clk);
    chk("cmd_ready_after_accept", 32'(cmd_ready), 32'd0);
    chk("busy_after_accept", 32'(busy), 32'd1);
    if (op != 3'd0) begin
      chk("alu_operand_a", alu_operand_a, a);
      chk("alu_operand_b", alu_operand_b, b);
      n = 0;
      while (alu_operation == op && n < 20) begin
        n++;
        @(negedge clk);
      end
      chk("alu_op_hold_cycles", 32'(n), 32'(L));
    end else begin
      chk("illegal_alu_idle", 32'(alu_operation), 32'd0);
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      chk("rsp_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    #1;
    chk("rst_alu_operation", 32'(alu_operation), 32'd0);
    chk("rst_operand_a", alu_operand_a, 32'd0);
    chk("rst_operand_b", alu_operand_b, 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_rsp_flags_tag", {25'd0, rsp_flags, rsp_tag}, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sticky", 32'(sticky_flags), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("cmd_ready_after_reset", 32'(cmd_ready), 32'd1);

    // Functional vectors
    issue(3'd1, 32'h3F80_0000, 32'h4000_0000, 4'h5, 32'h4040_0000, 3'b000); wait_done();
    issue(3'd3, 32'h4000_0000, 32'h4040_0000, 4'h6, 32'h40C0_0000, 3'b000); wait_done();
    issue(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 4'h9, 32'h0000_0000, 3'b100); wait_done();
    issue(3'd2, 32'h3F80_0000, 32'h3F80_0000, 4'h1, 32'h0000_0000, 3'b000); wait_done();
    issue(3'd4, 32'h3F80_0000, 32'h4000_0000, 4'h2, 32'h3F00_0000, 3'b000); wait_done();
    issue(3'd3, 32'h7F00_0000, 32'h4000_0000, 4'h3, 32'h7F80_0000, 3'b110); wait_done();
    issue(3'd3, 32'h0080_0000, 32'h3F00_0000, 4'h4, 32'h0040_0000, 3'b001); wait_done();
    issue(3'd6, 32'hFFFF_0000, 32'h0F0F_0F0F, 4'h7, 32'h0F0F_0000, 3'b000); wait_done();
    issue(3'd7, 32'h0000_0000, 32'h0000_0000, 4'h8, 32'hFFFF_FFFF, 3'b100); wait_done();

    // Backpressure with the next command waiting
    rsp_ready = 1'b0;
    issue(3'd1, 32'h3F80_0000, 32'h4000_0000, 4'hC, 32'h4040_0000, 3'b000);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = 3'd3; cmd_a = 32'h4000_0000; cmd_b = 32'h4040_0000; cmd_tag = 4'hD;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_cmd_ready_low", 32'(cmd_ready), 32'd0);
      chk("bp_rsp_valid_high", 32'(rsp_valid), 32'd1);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("no_accept_on_retire", 32'(cmd_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("cmd_ready_after_retire", 32'(cmd_ready), 32'd1);
    chk("rsp_valid_after_retire", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    push_exp(3'd3, 4'hD, 32'h40C0_0000, 3'b000);
    wait_done();

    // Reset during ISSUE
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = 3'd1; cmd_a = 32'h3F80_0000; cmd_b = 32'h4000_0000; cmd_tag = 4'hE;
    @(negedge clk);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("mid_issue_op", 32'(alu_operation), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_alu_operation", 32'(alu_operation), 32'd0);
    chk("midrst_operands", alu_operand_a | alu_operand_b, 32'd0);
    chk("midrst_rsp", {24'd0, rsp_valid, rsp_flags, rsp_tag}, 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    chk("no_rsp_after_reset", 32'(seen), 32'd0);
    chk("cmd_ready_after_midrst", 32'(cmd_ready), 32'd1);
    issue(3'd1, 32'h3F80_0000, 32'h4000_0000, 4'hA, 32'h4040_0000, 3'b000); wait_done();
    chk("sticky_after_clean", 32'(sticky_flags), 32'd0);

    // Sticky flags
    issue(3'd5, 32'h7F80_0000, 32'h0000_0000, 4'hB, 32'h7F80_0000, 3'b100); wait_done();
    chk("sticky_after_or", 32'(sticky_flags), STICKY_ON ? 32'd4 : 32'd0);
    issue(3'd1, 32'h3F80_0000, 32'h4000_0000, 4'h3, 32'h4040_0000, 3'b000); wait_done();
    chk("sticky_kept", 32'(sticky_flags), STICKY_ON ? 32'd4 : 32'd0);
    @(posedge clk); #1 sticky_clr = 1'b1;
    @(posedge clk); #1 sticky_clr = 1'b0;
    @(negedge clk);
    chk("sticky_cleared", 32'(sticky_flags), 32'd0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/fp_alu_cmd_master.md
Name: fp_alu_cmd_master

Overview:
- Sequential initiator that drives the single-precision floating-point ALU (add, sub, mul, div, or, and, not).
- Accepts commands from an upstream controller over a valid/ready channel and registers the operands.
- Holds them stable on the ALU inputs for a programmable settle time, then captures the result and flags.
- Returns the captured result with the command tag on a valid/ready response channel.

Parameters:
- ALU_LATENCY, 2, cycles the ALU inputs are held before sampling the result; legal range 1..15.
- TAG_W, 4, width of the command/response tag.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when high with cmd_valid at clk edge
- cmd_op  in  3  1 add, 2 sub, 3 mul, 4 div, 5 or, 6 and, 7 not, 0 illegal
- cmd_a  in  32  IEEE-754 single operand A
- cmd_b  in  32  IEEE-754 single operand B
- cmd_tag  in  TAG_W  returned unchanged with the response
- alu_operand_a  out  32  to ALU
- alu_operand_b  out  32  to ALU
- alu_operation  out  3  to ALU; 0 whenever not issuing
- alu_result  in  32  from ALU
- alu_exception  in  1  from ALU
- alu_overflow  in  1  from ALU
- alu_underflow  in  1  from ALU
- rsp_valid  out  1  response present
- rsp_ready  in  1  downstream accepts response
- rsp_result  out  32  captured result
- rsp_flags  out  3  {exception, overflow, underflow}
- rsp_tag  out  TAG_W  tag of the completed command
- busy  out  1  high in any state other than IDLE
- sticky_clr  in  1  clears sticky flags (optional feature)
- sticky_flags  out  3  accumulated {exception, overflow, underflow} (optional feature)

Behaviour:
- Reset: one clock domain; rst_n is asynchronous, active-low.
  - State goes to IDLE; all registered outputs are 0.
  - alu_operation, alu_operand_a/b, rsp_valid, rsp_result, rsp_flags, rsp_tag, busy and sticky_flags are all 0.
  - cmd_ready is 1 (combinational, high in IDLE) as soon as reset is released.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, register cmd_a, cmd_b, cmd_op and cmd_tag.
  - If cmd_op!=0: go to ISSUE and load the wait counter with ALU_LATENCY-1.
  - If cmd_op==0: go directly to RESP with rsp_result=0, rsp_flags=3'b100, rsp_tag=cmd_tag. The ALU is never driven.
- ISSUE:
  - alu_operation, alu_operand_a and alu_operand_b come from the registered command and are stable for exactly ALU_LATENCY cycles.
  - Counter decrements each cycle.
  - At the edge where counter==0, capture alu_result and the three flags into rsp_*; set rsp_valid=1; go to RESP.
  - At that same edge alu_operation returns to 0.
- Latency: rsp_valid rises ALU_LATENCY+1 cycles after the accept edge (1 cycle for illegal op).
- RESP:
  - rsp_valid=1; rsp_* held stable while rsp_ready=0, with unlimited backpressure.
  - On rsp_valid&&rsp_ready, clear rsp_valid and return to IDLE.
  - cmd_ready rises the following cycle; no command is accepted in the same cycle as response retirement.
- Single outstanding command at all times; cmd_ready=0 in ISSUE and RESP.
- cmd_* inputs are ignored outside IDLE. A cmd_valid held high across a busy period is accepted on the first IDLE cycle.
- The ALU inputs are never changed while alu_operation!=0.
- Reset asserted mid-ISSUE or mid-RESP: the operation and pending response are discarded, with no partial response.
- ALU_LATENCY outside 1..15 is a configuration error and has no defined behaviour.

Optional Feature:
- Macro FP_ALU_STICKY_FLAGS_EN.
- Defined:
  - On each response capture, sticky_flags |= captured flags; this includes the exception of an illegal op.
  - sticky_clr=1 clears sticky_flags at the next edge.
  - If a capture and sticky_clr occur in the same cycle, the result is the newly captured flags only.
- Not defined: sticky_flags is tied to 3'b000 and sticky_clr is ignored. The ports remain present.

Test Plan:
- Add with ALU_LATENCY=2: op=1, a=0x3F800000, b=0x40000000, tag=5.
  - Expect cmd_ready low the next cycle and alu_operation=1 for exactly 2 cycles.
  - rsp_valid rises 3 cycles after accept with rsp_result=0x40400000, rsp_flags=000, rsp_tag=5.
- Mul: op=3, a=0x40000000, b=0x40400000 -> rsp_result=0x40C00000, flags=000.
- Illegal op: op=0, tag=9 -> rsp_valid one cycle after accept, rsp_result=0, rsp_flags=100, rsp_tag=9, alu_operation never leaves 0.
- Backpressure: hold rsp_ready=0 for 10 cycles with the next cmd_valid high.
  - rsp_* stay stable and cmd_ready stays 0.
  - After rsp_ready=1 for one cycle, cmd_ready=1 on the following cycle and the second command is accepted.
- Reset mid-op: assert rst_n=0 during ISSUE.
  - All outputs go 0 immediately with no rsp_valid afterwards.
  - After release, cmd_ready=1 and a new add completes normally.
- Sticky (macro defined): op=5 with a=0x7F800000 gives flags=100 and sticky_flags=100.
  - A following clean add keeps sticky_flags=100.
  - sticky_clr pulse -> 000.
  - Without the macro, sticky_flags stays 000 throughout.
